eth_axis_rx_packer: RTL and testbench
=====================================

ETH_AXIS_RX_PACKER -- requirements
Module: eth_axis_rx_packer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the frame/error statistics counters.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port s_axis_tdata  input  8  received byte.
REQ-005 SHALL have port s_axis_tvalid  input  1  byte valid.
REQ-006 SHALL have port s_axis_tuser  input  1  per-byte error flag.
REQ-007 SHALL have port s_axis_tlast  input  1  last byte of frame.
REQ-008 SHALL have port s_axis_tready  output  1  byte accepted when high with tvalid.
REQ-009 SHALL have port m_axis_tdata  output  32  packed word; byte 0 in [7:0], byte 3 in [31:24].
REQ-010 SHALL have port m_axis_byte_count  output  2  index of last valid byte in word (3 = full word).
REQ-011 SHALL have port m_axis_tvalid  output  1  word valid.
REQ-012 SHALL have port m_axis_tuser  output  1  OR of s_axis_tuser over all bytes of the word.
REQ-013 SHALL have port m_axis_tlast  output  1  word contains last byte of frame.
REQ-014 SHALL have port m_axis_tready  input  1  downstream accepts word.
REQ-015 SHALL have port frame_cnt_o  output  CNT_WIDTH  frames delivered.
REQ-016 SHALL have port err_cnt_o  output  CNT_WIDTH  frames delivered with tuser set.

Function
REQ-017 SHALL pack input bytes little-endian into an accumulator with 2-bit byte index idx (0..3).
REQ-018 SHALL accept a byte only on s_axis_tvalid & s_axis_tready; s_axis_tready = !m_axis_tvalid | m_axis_tready, independent of s_axis_tvalid/tlast.
REQ-019 SHALL, on an accepted byte with idx==3 or s_axis_tlast==1, load the output register next cycle: tdata = accumulated bytes plus current byte, byte_count = idx, tlast = s_axis_tlast, tuser = OR of accumulated and current tuser; then idx <= 0 and accumulator tuser cleared.
REQ-020 SHALL otherwise, on an accepted byte, store it at lane idx, OR its tuser into the accumulator flag, and increment idx.
REQ-021 SHALL zero-fill tdata lanes above byte_count in every emitted word.
REQ-022 SHALL have latency of exactly one clk_i cycle from acceptance of the completing byte to m_axis_tvalid high.
REQ-023 SHALL hold m_axis_tdata/byte_count/tuser/tlast/tvalid stable while m_axis_tvalid & !m_axis_tready.
REQ-024 SHALL clear m_axis_tvalid after handshake unless a new word loads the same cycle (back-to-back sustained at one byte per cycle with m_axis_tready high).
REQ-025 SHALL treat a 1-byte frame (tlast at idx 0) as a word with byte_count 0 and tdata[31:8]=0.
REQ-026 SHALL wrap idx 3->0 with no idle cycle when output register is free or draining.
REQ-027 SHALL ignore s_axis_tdata/tuser/tlast when not accepted.

Reset
REQ-028 SHALL, on rst_i high at a clk_i edge, set idx=0, accumulator=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_byte_count=0, m_axis_tuser=0, m_axis_tlast=0, frame_cnt_o=0, err_cnt_o=0.
REQ-029 SHALL discard any partial word or pending output word when reset asserts mid-frame; s_axis_tready reads 1 during and after reset.

Configuration
REQ-030 SHALL, with ETH_RX_PACK_STATS_EN defined, increment frame_cnt_o on each output handshake with m_axis_tlast=1, and err_cnt_o when additionally m_axis_tuser=1; both saturate at all-ones.
REQ-031 SHALL, without ETH_RX_PACK_STATS_EN, drive frame_cnt_o and err_cnt_o constant 0 and synthesize no counter logic; ports remain present.

Verification
REQ-032 SHALL cover: bytes 11,22,33,44 (tlast on 44), tready=1 -> one word 0x44332211, byte_count 3, tlast 1, one cycle after byte 44.
REQ-033 SHALL cover: 6-byte frame 01..06 -> words 0x04030201 (bc 3, tlast 0) then 0x00000605 (bc 1, tlast 1).
REQ-034 SHALL cover: single byte AB with tlast and tuser -> word 0x000000AB, bc 0, tuser 1, tlast 1; err_cnt_o=1 with macro, 0 without.
REQ-035 SHALL cover: m_axis_tready held low 5 cycles while word pending -> s_axis_tready low, output stable, no byte lost; release -> stream resumes in order.
REQ-036 SHALL cover: rst_i pulsed after 2 bytes of a frame -> no word emitted; next frame 0xA1..0xA4 packs as 0xA4A3A2A1.
REQ-037 SHALL cover: CNT_WIDTH=2, 5 good frames with macro -> frame_cnt_o saturates at 3.

Source files
------------

// File: rtl/eth_axis_rx_packer.sv
// Packs a received Ethernet byte stream into little-endian 32-bit words with a one-cycle output register.
// Optional frame/error statistics counters are built only when ETH_RX_PACK_STATS_EN is defined.
module eth_axis_rx_packer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic [1:0]           m_axis_byte_count,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] frame_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    logic [1:0]  idx_reg;
    logic [31:0] acc_data_reg;
    logic        acc_user_reg;

    logic [31:0] m_data_reg;
    logic [1:0]  m_bc_reg;
    logic        m_user_reg;
    logic        m_last_reg;
    logic        m_valid_reg;

    logic        accept;
    logic        complete;
    logic [31:0] word_next;

    // The output register is free or draining this cycle, so a completing byte can always load it.
    assign s_axis_tready = !m_valid_reg | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign complete      = accept & ((idx_reg == 2'd3) | s_axis_tlast);

    // Lanes below idx come from the accumulator, lane idx is the live byte, lanes above are zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign word_next[gi*8 +: 8] = (LANE < idx_reg)  ? acc_data_reg[gi*8 +: 8] :
                                          (LANE == idx_reg) ? s_axis_tdata : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_reg      <= 2'd0;
            acc_data_reg <= 32'd0;
            acc_user_reg <= 1'b0;
            m_data_reg   <= 32'd0;
            m_bc_reg     <= 2'd0;
            m_user_reg   <= 1'b0;
            m_last_reg   <= 1'b0;
            m_valid_reg  <= 1'b0;
        end else begin
            if (m_valid_reg && m_axis_tready) begin
                m_valid_reg <= 1'b0;
            end
            if (complete) begin
                m_data_reg   <= word_next;
                m_bc_reg     <= idx_reg;
                m_user_reg   <= acc_user_reg | s_axis_tuser;
                m_last_reg   <= s_axis_tlast;
                m_valid_reg  <= 1'b1;
                idx_reg      <= 2'd0;
                acc_user_reg <= 1'b0;
            end else if (accept) begin
                acc_data_reg[{idx_reg, 3'b000} +: 8] <= s_axis_tdata;
                acc_user_reg <= acc_user_reg | s_axis_tuser;
                idx_reg      <= idx_reg + 2'd1;
            end
        end
    end

    assign m_axis_tdata      = m_data_reg;
    assign m_axis_byte_count = m_bc_reg;
    assign m_axis_tuser      = m_user_reg;
    assign m_axis_tlast      = m_last_reg;
    assign m_axis_tvalid     = m_valid_reg;

`ifdef ETH_RX_PACK_STATS_EN
    logic [CNT_WIDTH-1:0] frame_cnt_reg;
    logic [CNT_WIDTH-1:0] err_cnt_reg;
    logic                 frame_done;

    assign frame_done = m_valid_reg & m_axis_tready & m_last_reg;

    // Saturating counters: a stuck-at-max count is more useful than a silent wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_reg <= '0;
            err_cnt_reg   <= '0;
        end else if (frame_done) begin
            if (frame_cnt_reg != '1) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_WIDTH'(1);
            end
            if (m_user_reg && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign frame_cnt_o = frame_cnt_reg;
    assign err_cnt_o   = err_cnt_reg;
`else
    assign frame_cnt_o = '0;
    assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_eth_axis_rx_packer.sv
// Directed bench for eth_axis_rx_packer: every emitted word is matched against a queue of hand-computed words.
module tb_eth_axis_rx_packer;

`ifdef ETH_RX_PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  bc;
        logic        u;
        logic        l;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tuser = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [1:0]  m_bc;
    logic        m_tvalid;
    logic        m_tuser;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    logic        s_tready2;
    logic [31:0] m_tdata2;
    logic [1:0]  m_bc2;
    logic        m_tvalid2;
    logic        m_tuser2;
    logic        m_tlast2;
    logic [1:0]  frame_cnt2;
    logic [1:0]  err_cnt2;

    int    vectors_applied = 0;
    int    miscompares = 0;
    word_t exp_q[$];

    always #5 clk = ~clk;

    eth_axis_rx_packer #(.CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_byte_count(m_bc), .m_axis_tvalid(m_tvalid),
        .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
    );

    eth_axis_rx_packer #(.CNT_WIDTH(2)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_byte_count(m_bc2), .m_axis_tvalid(m_tvalid2),
        .m_axis_tuser(m_tuser2), .m_axis_tlast(m_tlast2), .m_axis_tready(m_tready),
        .frame_cnt_o(frame_cnt2), .err_cnt_o(err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // A handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", m_tdata, 32'hFFFF_FFFF);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("word_data", m_tdata, w.d);
                check("word_meta", {28'd0, m_bc, m_tuser, m_tlast}, {28'd0, w.bc, w.u, w.l});
            end
        end
    end

    task automatic expect_word(input logic [31:0] d, input logic [1:0] bc, input logic u, input logic l);
        word_t w;
        w.d = d; w.bc = bc; w.u = u; w.l = l;
        exp_q.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic u, input logic l);
        int guard = 0;
        @(negedge clk);
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        while (!s_tready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("tready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        // Junk on the side-band lines while idle must be ignored.
        s_tvalid = 1'b0; s_tdata = 8'hEE; s_tuser = 1'b1; s_tlast = 1'b1;
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || m_tvalid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tready", {31'd0, s_tready}, 32'd1);
        check("rst_outputs", {m_tvalid, m_tuser, m_tlast, m_bc}, 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_counters", {frame_cnt, err_cnt}, 32'd0);
        rst = 1'b0;

        // Single full word, one cycle after the last byte.
        expect_word(32'h44332211, 2'd3, 1'b0, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        check("no_early_valid", {31'd0, m_tvalid}, 32'd0);
        send_byte(8'h44, 1'b0, 1'b1);
        check("latency_valid", {31'd0, m_tvalid}, 32'd1);
        check("latency_data", m_tdata, 32'h44332211);
        wait_drain();

        // Six-byte frame: full word then zero-filled partial word.
        expect_word(32'h04030201, 2'd3, 1'b0, 1'b0);
        expect_word(32'h00000605, 2'd1, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, i == 6);
        wait_drain();

        // One-byte errored frame.
        expect_word(32'h000000AB, 2'd0, 1'b1, 1'b1);
        send_byte(8'hAB, 1'b1, 1'b1);
        check("one_byte_data", m_tdata, 32'h000000AB);
        wait_drain();
        check("frame_cnt_3", {16'd0, frame_cnt}, STATS ? 32'd3 : 32'd0);
        check("err_cnt_1", {16'd0, err_cnt}, STATS ? 32'd1 : 32'd0);

        // Downstream stall for five cycles with a word pending.
        @(posedge clk);
        #2 m_tready = 1'b0;
        expect_word(32'h13121110, 2'd3, 1'b0, 1'b0);
        expect_word(32'h17161514, 2'd3, 1'b0, 1'b1);
        fork
            begin
                for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 1'b0, i == 7);
            end
            begin
                int guard = 0;
                while (!m_tvalid && guard < 100) begin
                    @(negedge clk);
                    guard++;
                end
                if (guard >= 100) check("stall_timeout", 32'd0, 32'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("stall_tready", {31'd0, s_tready}, 32'd0);
                    check("stall_hold", m_tdata, 32'h13121110);
                end
                @(posedge clk);
                #2 m_tready = 1'b1;
            end
        join
        wait_drain();

        // Reset in mid-frame drops the partial word and clears the counters.
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("midrst_tready", {31'd0, s_tready}, 32'd1);
        check("midrst_counters", {frame_cnt, err_cnt}, 32'd0);
        rst = 1'b0;
        expect_word(32'hA4A3A2A1, 2'd3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA1 + i), 1'b0, i == 3);
        wait_drain();

        // Error in a middle byte of a three-byte frame.
        expect_word(32'h00C3C2C1, 2'd2, 1'b1, 1'b1);
        send_byte(8'hC1, 1'b0, 1'b0);
        send_byte(8'hC2, 1'b1, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b1);
        wait_drain();

        // Four more good frames push the 2-bit counter into saturation.
        for (int i = 0; i < 4; i++) begin
            expect_word(32'(8'hD0 + i), 2'd0, 1'b0, 1'b1);
            send_byte(8'(8'hD0 + i), 1'b0, 1'b1);
        end
        wait_drain();
        check("frame_cnt_6", {16'd0, frame_cnt}, STATS ? 32'd6 : 32'd0);
        check("err_cnt_after_rst", {16'd0, err_cnt}, STATS ? 32'd1 : 32'd0);
        check("sat_frame_cnt", {30'd0, frame_cnt2}, STATS ? 32'd3 : 32'd0);
        check("sat_err_cnt", {30'd0, err_cnt2}, STATS ? 32'd1 : 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
